// File: rtl/time_counter_bcd.sv
// rtl/time_counter_bcd.sv - HH:MM:SS BCD time counter with prescaler and set-mode buttons
module time_counter_bcd #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       set_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_tick
);

  localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc;
  logic [1:0]    hour_sync, min_sync;
  logic          hour_prev, min_prev;
  logic          hour_pulse, min_pulse;
  logic          advance;
  logic          sec_wrap, min_wrap, hour_wrap;
  logic [3:0]    su_inc, st_inc, mu_inc, mt_inc, hu_inc, ht_inc;
  logic [3:0]    su_n, st_n, mu_n, mt_n, hu_n, ht_n;

  // Two-flop synchronizers plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_sync <= 2'b00;
      min_sync  <= 2'b00;
      hour_prev <= 1'b0;
      min_prev  <= 1'b0;
    end else begin
      hour_sync <= {hour_sync[0], btn_hour};
      min_sync  <= {min_sync[0], btn_min};
      hour_prev <= hour_sync[1];
      min_prev  <= min_sync[1];
    end
  end

  assign hour_pulse = hour_sync[1] & ~hour_prev;
  assign min_pulse  = min_sync[1] & ~min_prev;

  assign advance = run_en & ~set_mode & (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= advance;
      if (set_mode)
        presc <= '0;
      else if (run_en)
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end
  end

  assign sec_wrap  = (sec_tens == 4'd5) && (sec_units == 4'd9);
  assign min_wrap  = (min_tens == 4'd5) && (min_units == 4'd9);
  assign hour_wrap = (hour_tens == 4'd2) && (hour_units == 4'd3);

  assign su_inc = (sec_units == 4'd9) ? 4'd0 : sec_units + 4'd1;
  assign st_inc = (sec_units != 4'd9) ? sec_tens : (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
  assign mu_inc = (min_units == 4'd9) ? 4'd0 : min_units + 4'd1;
  assign mt_inc = (min_units != 4'd9) ? min_tens : (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
  assign hu_inc = (hour_wrap || hour_units == 4'd9) ? 4'd0 : hour_units + 4'd1;
  assign ht_inc = hour_wrap ? 4'd0 : (hour_units == 4'd9) ? hour_tens + 4'd1 : hour_tens;

  // Whole cascade resolves combinationally so 23:59:59 -> 00:00:00 lands on one edge.
  always_comb begin
    su_n = sec_units;
    st_n = sec_tens;
    mu_n = min_units;
    mt_n = min_tens;
    hu_n = hour_units;
    ht_n = hour_tens;
    if (set_mode) begin
      su_n = 4'd0;
      st_n = 4'd0;
      if (min_pulse) begin
        mu_n = mu_inc;
        mt_n = mt_inc;
      end
      if (hour_pulse) begin
        hu_n = hu_inc;
        ht_n = ht_inc;
      end
    end else if (advance) begin
      su_n = su_inc;
      st_n = st_inc;
      if (sec_wrap) begin
        mu_n = mu_inc;
        mt_n = mt_inc;
        if (min_wrap) begin
          hu_n = hu_inc;
          ht_n = ht_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_units  <= 4'd0;
      sec_tens   <= 4'd0;
      min_units  <= 4'd0;
      min_tens   <= 4'd0;
      hour_units <= 4'd0;
      hour_tens  <= 4'd0;
    end else begin
      sec_units  <= su_n;
      sec_tens   <= st_n;
      min_units  <= mu_n;
      min_tens   <= mt_n;
      hour_units <= hu_n;
      hour_tens  <= ht_n;
    end
  end

endmodule

// File: tb/tb_time_counter_bcd.sv
// tb/tb_time_counter_bcd.sv - scoreboard bench for time_counter_bcd at CLK_FREQ=4
module tb_time_counter_bcd;

  localparam int CLK_FREQ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_en = 1'b0;
  logic       set_mode = 1'b0;
  logic       btn_hour = 1'b0;
  logic       btn_min = 1'b0;
  logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
  logic       sec_tick;
  logic [24:0] obs;

  int checks = 0;
  int failures = 0;
  int mh = 0;
  int mm = 0;

  typedef struct {
    string       tag;
    logic [24:0] exp;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  time_counter_bcd #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .set_mode   (set_mode),
    .btn_hour   (btn_hour),
    .btn_min    (btn_min),
    .hour_tens  (hour_tens),
    .hour_units (hour_units),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  assign obs = {sec_tick, hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};

  function automatic logic [24:0] pack(int h, int m, int s, bit t);
    logic [24:0] r;
    r = {t, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  function automatic logic [24:0] pack_secs(int t, bit tk);
    int x;
    x = t % 86400;
    return pack(x / 3600, (x / 60) % 60, x % 60, tk);
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [24:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_compare();
    sb_entry_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Set-mode press: two cycles high, three low so the edge detector fully re-arms.
  task automatic press(input bit h, input bit m, input string tag);
    btn_hour = h;
    btn_min  = m;
    cycle(2);
    btn_hour = 1'b0;
    btn_min  = 1'b0;
    if (h) mh = (mh + 1) % 24;
    if (m) mm = (mm + 1) % 60;
    sb_push(tag, pack(mh, mm, 0, 1'b0));
    cycle(3);
    sb_pop_compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycle(2);
    sb_push("reset", pack(0, 0, 0, 1'b0));
    sb_pop_compare();

    // Free run: tick on edges 4, 8, 12
    rst_n  = 1'b1;
    run_en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      sb_push("run12", pack_secs(e / CLK_FREQ, (e % CLK_FREQ) == 0));
      cycle(1);
      sb_pop_compare();
    end

    // Frozen with run_en=0, then buttons outside set mode
    run_en = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      sb_push("frozen", pack(0, 0, 3, 1'b0));
      cycle(1);
      sb_pop_compare();
    end
    btn_hour = 1'b1;
    btn_min  = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      if (e == 3) begin
        btn_hour = 1'b0;
        btn_min  = 1'b0;
      end
      sb_push("btn_ignored", pack(0, 0, 3, 1'b0));
      cycle(1);
      sb_pop_compare();
    end

    // Set mode with run_en=0: seconds forced to 00, held btn_min gives one step on edge 3
    set_mode = 1'b1;
    sb_push("set_entry", pack(0, 0, 0, 1'b0));
    cycle(1);
    sb_pop_compare();
    btn_min = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      sb_push("held_min", pack(0, (e >= 3) ? 1 : 0, 0, 1'b0));
      cycle(1);
      sb_pop_compare();
    end
    btn_min = 1'b0;
    cycle(3);
    mm = 1;
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, "min_step");
    sb_push("min_wrap", pack(0, 0, 0, 1'b0));
    sb_pop_compare();

    // 09:59 then both buttons together
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, "hour_step");
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, "min_to_59");
    press(1'b1, 1'b1, "both_btn");
    sb_push("both_btn_1000", pack(10, 0, 0, 1'b0));
    sb_pop_compare();

    // Preload 23:59, then run across the full midnight cascade
    for (int i = 0; i < 13; i++) press(1'b1, 1'b0, "hour_to_23");
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, "min_to_59b");
    run_en = 1'b1;
    cycle(2);
    set_mode = 1'b0;
    for (int e = 1; e <= 240; e++) begin
      sb_push("cascade", pack_secs(23 * 3600 + 59 * 60 + e / CLK_FREQ, (e % CLK_FREQ) == 0));
      cycle(1);
      sb_pop_compare();
    end

    // Count to 00:00:07 with prescaler at 2, then reset mid-count
    for (int e = 1; e <= 30; e++) begin
      sb_push("to_07", pack_secs(e / CLK_FREQ, (e % CLK_FREQ) == 0));
      cycle(1);
      sb_pop_compare();
    end
    rst_n = 1'b0;
    #2;
    sb_push("async_reset", pack(0, 0, 0, 1'b0));
    sb_pop_compare();
    cycle(1);
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      sb_push("post_reset_tick", pack_secs(e / CLK_FREQ, (e % CLK_FREQ) == 0));
      cycle(1);
      sb_pop_compare();
    end

    // Button held through reset in set mode: one increment on third edge after release
    rst_n    = 1'b0;
    set_mode = 1'b1;
    btn_hour = 1'b1;
    cycle(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      sb_push("held_thru_reset", pack((e >= 3) ? 1 : 0, 0, 0, 1'b0));
      cycle(1);
      sb_pop_compare();
    end
    btn_hour = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
